// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

   // One prefetch FIFO entry: the byte PC and the instruction fetched there.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam int unsigned FETCH_ENTRY_W    = 64;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_ctrl_fifo_sync.sv
// Synchronous FIFO with a single-cycle flush, used as the fetch prefetch buffer.
// The caller must never push when full without a same-cycle pop, nor pop when empty.
module fifo_sync #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   // Storage, pointers and occupancy; flush empties without touching storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational
// instruction memory and buffers {pc, instr} pairs for decode.
// Optional build macro: IFETCH_ALIGN_CHECK_EN (misaligned redirect sets a
// sticky fetch_err and freezes fetch).
//
// Decode handshake: an entry transfers on a rising edge where if_valid and
// if_ready are both high; if_valid/if_pc/if_instr stay stable until then.
// A redirect in the same cycle wins and the transfer is discarded.
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_err
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   pc_q, pc_d;
   logic          push, pop, full, empty;
   logic          freeze;
   fetch_entry_t  wr_entry, head_entry;
   logic [CW-1:0] unused_fifo_count;

`ifdef IFETCH_ALIGN_CHECK_EN
   logic err_q, err_d;
   logic misalign;

   assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign err_d    = err_q || misalign;
   assign freeze   = err_q || misalign;

   // Sticky misalignment flag, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign fetch_err = err_q;
`else
   logic unused_align_bits;

   assign unused_align_bits = ^redirect_pc[1:0];
   assign freeze            = 1'b0;
   assign fetch_err         = 1'b0;
`endif

   assign pop  = if_valid && if_ready && !redirect_valid;
   assign push = !redirect_valid && !freeze && (!full || pop);

   // Next fetch PC: redirect target (word aligned), sequential step, or hold.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         if (!freeze) begin
            pc_d = {redirect_pc[31:2], 2'b00};
         end
      end else if (push) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   // Fetch PC register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign wr_entry = '{pc: pc_q, instr: imem_rd};

   fifo_sync #(
      .DEPTH (DEPTH),
      .WIDTH (FETCH_ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (redirect_valid),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .rdata_o (head_entry),
      .count_o (unused_fifo_count),
      .full_o  (full),
      .empty_o (empty)
   );

   assign imem_a   = {2'b00, pc_q[31:2]};
   assign if_valid = !empty;
   assign if_pc    = head_entry.pc;
   assign if_instr = head_entry.instr;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: reset state, streaming, stall, toggled
// ready, redirect flush, PC wrap, async reset and misaligned redirect.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  logic [31:0] imem [256];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;

  // clock / reset block
  always #5 clk = ~clk;

  assign imem_rd = imem[imem_a[7:0]];

  ifetch_ctrl #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: advance one edge and sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_instr"}, if_instr, 32'h1000_0000 + {24'b0, pc[9:2]});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h1000_0000 + i;
    reset          = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();

    // reset state
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);
    check("rst_imem_a", imem_a, 32'd0);

    // stream with if_ready high: head after edge k is 4*(k-1)
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_head("stream", 32'(4 * (k - 1)));
    end

    // async reset between edges
    #2 reset = 1'b1;
    #1;
    check("async_valid", {31'b0, if_valid}, 32'd0);
    check("async_imem_a", imem_a, 32'd0);
    if_ready = 1'b0;
    step();
    reset = 1'b0;

    // stall: 10 edges with if_ready low, FIFO saturates at 0..C
    for (int k = 0; k < 10; k++) step();
    check("stall_imem_a", imem_a, 32'd4);
    check_head("stall", 32'h0);

    // drain with push on each pop
    if_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_head("drain", 32'(4 * k));
    end

    // toggle ready with a full FIFO
    exp_pc = 32'h10;
    for (int k = 0; k < 6; k++) begin
      if_ready = k[0];
      step();
      if (k[0]) exp_pc = exp_pc + 32'd4;
      check_head("toggle", exp_pc);
    end

    // redirect to 0x40 while full with ready high
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", {31'b0, if_valid}, 32'd0);
    check("redir_imem_a", imem_a, 32'h10);
    step();
    check_head("redir_tgt", 32'h40);
    step();
    check_head("redir_next", 32'h44);

    // PC wrap FFFF_FFFC -> 0
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    check("wrap_imem_a", imem_a, 32'h3FFF_FFFE);
    step();
    check("wrap_pc0", if_pc, 32'hFFFF_FFF8);
    check("wrap_instr0", if_instr, 32'h1000_00FE);
    step();
    check("wrap_pc1", if_pc, 32'hFFFF_FFFC);
    check("wrap_instr1", if_instr, 32'h1000_00FF);
    check("wrap_imem_a0", imem_a, 32'h0);
    step();
    check_head("wrap_zero", 32'h0);
    check("wrap_imem_a1", imem_a, 32'h1);

    // misaligned redirect to 0x42
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    check("mis_valid", {31'b0, if_valid}, 32'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
    check("mis_err", {31'b0, fetch_err}, 32'd1);
    check("mis_imem_a", imem_a, 32'h1);
    step();
    step();
    check("mis_frozen_valid", {31'b0, if_valid}, 32'd0);
    check("mis_frozen_imem_a", imem_a, 32'h1);
    check("mis_sticky_err", {31'b0, fetch_err}, 32'd1);
`else
    check("mis_err", {31'b0, fetch_err}, 32'd0);
    check("mis_imem_a", imem_a, 32'h10);
    step();
    check_head("mis_resume", 32'h40);
    check("mis_err_after", {31'b0, fetch_err}, 32'd0);
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the MIPS32 core. Owns the fetch PC, drives the word-indexed combinational instruction memory (read data valid in the same cycle as the address), and buffers fetched {pc, instr} pairs in a small prefetch FIFO. Decode consumes the FIFO through a valid/ready handshake. A branch/jump redirect flushes the FIFO and restarts fetch.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_a  out  32  word index to the instruction memory, equal to {2'b00, pc[31:2]}.
- imem_rd  in  32  instruction word returned combinationally for imem_a.
- if_valid  out  1  head FIFO entry is valid.
- if_ready  in  1  decode accepts the head entry; pop occurs when if_valid && if_ready.
- if_instr  out  32  instruction at the head.
- if_pc  out  32  byte PC of the head instruction.
- redirect_valid  in  1  one-cycle pulse requesting a flush and refetch.
- redirect_pc  in  32  target byte address.
- fetch_err  out  1  sticky misalignment flag; 0 unless IFETCH_ALIGN_CHECK_EN is defined.

Behaviour:
- Reset (asynchronous, active-high):
  - pc = RESET_PC, count = 0, read/write pointers = 0.
  - if_valid = 0, if_instr = 0, if_pc = 0, fetch_err = 0.
  - imem_a reflects RESET_PC immediately.
- Push rule:
  - push = !redirect_valid && (count < DEPTH || pop).
  - On push: write {pc, imem_rd} at the write pointer, then pc <= pc + 4 (32-bit wrap, FFFF_FFFC -> 0000_0000).
- Pop rule:
  - pop = if_valid && if_ready; advances the read pointer.
  - Push and pop in the same cycle leave count unchanged. Push is allowed when full only if a pop happens in that cycle.
- Outputs:
  - if_valid = (count != 0).
  - if_instr and if_pc come from the head entry. They are registered FIFO storage, so no combinational path from imem_rd.
- Latency:
  - First edge after reset release writes RESET_PC; if_valid rises the following cycle.
  - Steady state: one instruction per cycle when if_ready is held high.
- Redirect (highest priority):
  - Flush: count <= 0, pointers <= 0, pc <= {redirect_pc[31:2], 2'b00}.
  - No push and no effective pop that cycle; a concurrent if_ready handshake is discarded.
  - if_valid is 0 the cycle after the redirect. The target instruction becomes valid one cycle later (2-cycle redirect penalty).
- Stall: if_ready = 0 with the FIFO full holds pc, imem_a and all entries stable.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Reset asserted mid-operation discards all entries at once; no partial state survives.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_err (sticky until reset), flushes the FIFO, and freezes fetch: no further pushes, pc held.
  - Aligned redirects behave normally while fetch_err = 0.
- Undefined: redirect_pc[1:0] are silently ignored; fetch_err is tied to 0.

Decomposition:
- Package ifetch_pkg:
  - fetch entry type {pc[31:0], instr[31:0]}.
  - PC_STEP = 4.
  - Default RESET_PC.
- Sub-module fifo_sync (DEPTH, WIDTH = 64): synchronous FIFO with a flush input, push/pop, count, full/empty.
- ifetch_ctrl keeps the PC register, the push/redirect logic and the error flag.

Test Plan:
- Reset release with if_ready = 1 and imem preloaded with word i = 32'h1000_0000 + i -> if_valid rises 2 cycles after the reset edge; then if_pc = 0, 4, 8, … with instr 1000_0000, 1000_0001, … on consecutive cycles.
- if_ready = 0 for 10 cycles -> count saturates at 4; imem_a holds 4 (pc = 0x10); on release, entries 0x0..0xC drain in order with no duplicates or gaps.
- Redirect to 0x40 while full and if_ready = 1 -> if_valid = 0 next cycle; the following cycle if_pc = 0x40; the head popped in the redirect cycle is not consumed twice.
- Toggle if_ready every cycle with a full FIFO -> push accepted on each pop cycle; the if_pc sequence stays strictly +4 with no loss.
- Async reset asserted mid-stream, between clock edges -> if_valid = 0 and imem_a = RESET_PC without a clock edge.
- With IFETCH_ALIGN_CHECK_EN, redirect to 0x42 -> fetch_err = 1, if_valid stays 0, imem_a frozen; without the macro -> fetch resumes at 0x40 and fetch_err = 0.
